// File: rtl/mccu_fsm.sv
// Multicycle MIPS control unit: registered state, outputs decoded each cycle; CPI 2..5 with no wait states.
// Optional MCCU_MEM_WAIT_EN: IF/MEM stall on mem_ready with a WAIT_MAX timeout that raises mem_err.
module mccu_fsm #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsrc,
  output logic [2:0] state,
  output logic       mem_err
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic i_shift, r_alu, i_imm, i_br, known;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type & (func == 6'b100000);
  assign i_sub  = r_type & (func == 6'b100010);
  assign i_and  = r_type & (func == 6'b100100);
  assign i_or   = r_type & (func == 6'b100101);
  assign i_xor  = r_type & (func == 6'b100110);
  assign i_sll  = r_type & (func == 6'b000000);
  assign i_srl  = r_type & (func == 6'b000010);
  assign i_sra  = r_type & (func == 6'b000011);
  assign i_jr   = r_type & (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lui  = (op == 6'b001111);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign i_shift = i_sll | i_srl | i_sra;
  assign r_alu   = i_add | i_sub | i_and | i_or | i_xor | i_shift;
  assign i_imm   = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign i_br    = i_beq | i_bne;
  assign known   = r_alu | i_jr | i_imm | i_lw | i_sw | i_br | i_j | i_jal;

  // Sign extension is needed both for the branch target in ID and the immediate in EXE.
  assign sext = i_addi | i_lw | i_sw | i_beq | i_bne;

  logic [3:0] alu_code;
  always_comb begin
    alu_code = 4'b0000;
    if (i_sub)                          alu_code = 4'b0100;
    else if (i_and | i_andi)            alu_code = 4'b0001;
    else if (i_or | i_ori)              alu_code = 4'b0101;
    else if (i_xor | i_xori | i_br)     alu_code = 4'b0010;
    else if (i_lui)                     alu_code = 4'b0110;
    else if (i_sll)                     alu_code = 4'b0011;
    else if (i_srl)                     alu_code = 4'b0111;
    else if (i_sra)                     alu_code = 4'b1111;
  end

  logic mem_ok;
  logic timeout;

`ifdef MCCU_MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             mem_acc;
  logic [2:0]       state_nxt_w;

  assign mem_acc = (state == S_IF) | ((state == S_MEM) & (i_lw | i_sw));
  assign mem_ok  = mem_ready;
  assign timeout = mem_acc & ~mem_ready & (wait_cnt == CNT_W'(WAIT_MAX - 1));

  // Counter restarts whenever a state is (re)entered, including IF after a timeout.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= timeout;
      if ((state_nxt_w != state) || timeout)
        wait_cnt <= '0;
      else if (mem_acc & ~mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
  assign mem_err = mem_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = mem_ready | (WAIT_MAX == 0);
  assign mem_ok  = 1'b1;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  logic [2:0] state_nxt;
  logic       wpc_en, wir_en, wmem_en, wreg_en;

  always_comb begin
    state_nxt = state;
    wpc_en    = 1'b0;
    wir_en    = 1'b0;
    wmem_en   = 1'b0;
    wreg_en   = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    shift     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluc      = 4'b0000;
    pcsrc     = 2'b00;
    case (state)
      S_IF: begin
        alusrcb = 2'b01;
        if (timeout) begin
          state_nxt = S_IF;
        end else if (mem_ok) begin
          wir_en    = 1'b1;
          wpc_en    = 1'b1;
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        alusrcb = 2'b11;
        if (i_j | i_jal) begin
          wpc_en    = 1'b1;
          pcsrc     = 2'b11;
          wreg_en   = i_jal;
          jal       = i_jal;
          state_nxt = S_IF;
        end else if (i_jr) begin
          wpc_en    = 1'b1;
          pcsrc     = 2'b10;
          state_nxt = S_IF;
        end else if (known) begin
          state_nxt = S_EXE;
        end else begin
          state_nxt = S_IF;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        alusrcb = (r_type | i_br) ? 2'b00 : 2'b10;
        aluc    = alu_code;
        shift   = i_shift;
        if (i_br) begin
          if ((i_beq & z) | (i_bne & ~z)) begin
            wpc_en = 1'b1;
            pcsrc  = 2'b01;
          end
          state_nxt = S_IF;
        end else if (i_lw | i_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (timeout) begin
          state_nxt = S_IF;
        end else if (i_sw) begin
          // Write strobe stays up across a stall; the access ends when memory reports ready.
          wmem_en = 1'b1;
          if (mem_ok) state_nxt = S_IF;
        end else if (i_lw) begin
          if (mem_ok) state_nxt = S_WB;
        end else begin
          state_nxt = S_IF;
        end
      end
      S_WB: begin
        wreg_en   = 1'b1;
        regrt     = i_imm | i_lw;
        m2reg     = i_lw;
        state_nxt = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

`ifdef MCCU_MEM_WAIT_EN
  assign state_nxt_w = state_nxt;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IF;
    else       state <= state_nxt;
  end

  // Architectural writes are suppressed for as long as reset is held.
  assign wpc  = wpc_en  & clrn;
  assign wir  = wir_en  & clrn;
  assign wmem = wmem_en & clrn;
  assign wreg = wreg_en & clrn;

endmodule

// File: tb/tb_mccu_fsm.sv
// Self-checking bench for mccu_fsm: directed instruction flows plus randomized instructions vs a CPI/path model.
module tb_mccu_fsm;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b1;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;
  logic       mem_err;

  mccu_fsm #(.WAIT_MAX(15)) dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc), .state(state), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  localparam int C_RALU = 0, C_SHF = 1, C_IALU = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_NOP = 10;

  logic [5:0] t_op  [20];
  logic [5:0] t_fn  [20];
  int         t_cls [20];
  logic [3:0] t_alu [20];
  logic       t_sx  [20];

  task automatic put(input int i, input logic [5:0] o, input logic [5:0] f, input int c,
                     input logic [3:0] a, input logic s);
    t_op[i] = o; t_fn[i] = f; t_cls[i] = c; t_alu[i] = a; t_sx[i] = s;
  endtask

  task automatic load_table;
    put(0,  6'b000000, 6'b100000, C_RALU, 4'b0000, 1'b0);
    put(1,  6'b000000, 6'b100010, C_RALU, 4'b0100, 1'b0);
    put(2,  6'b000000, 6'b100100, C_RALU, 4'b0001, 1'b0);
    put(3,  6'b000000, 6'b100101, C_RALU, 4'b0101, 1'b0);
    put(4,  6'b000000, 6'b100110, C_RALU, 4'b0010, 1'b0);
    put(5,  6'b000000, 6'b000000, C_SHF,  4'b0011, 1'b0);
    put(6,  6'b000000, 6'b000010, C_SHF,  4'b0111, 1'b0);
    put(7,  6'b000000, 6'b000011, C_SHF,  4'b1111, 1'b0);
    put(8,  6'b000000, 6'b001000, C_JR,   4'b0000, 1'b0);
    put(9,  6'b001000, 6'b000000, C_IALU, 4'b0000, 1'b1);
    put(10, 6'b001100, 6'b000000, C_IALU, 4'b0001, 1'b0);
    put(11, 6'b001101, 6'b000000, C_IALU, 4'b0101, 1'b0);
    put(12, 6'b001110, 6'b000000, C_IALU, 4'b0010, 1'b0);
    put(13, 6'b001111, 6'b000000, C_IALU, 4'b0110, 1'b0);
    put(14, 6'b100011, 6'b000000, C_LW,   4'b0000, 1'b1);
    put(15, 6'b101011, 6'b000000, C_SW,   4'b0000, 1'b1);
    put(16, 6'b000100, 6'b000000, C_BEQ,  4'b0010, 1'b1);
    put(17, 6'b000101, 6'b000000, C_BNE,  4'b0010, 1'b1);
    put(18, 6'b000010, 6'b000000, C_J,    4'b0000, 1'b0);
    put(19, 6'b000011, 6'b000000, C_JAL,  4'b0000, 1'b0);
  endtask

  function automatic bit is_defined(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < 20; i++)
      if (t_op[i] == o && (o != 6'd0 || t_fn[i] == f)) return 1'b1;
    return 1'b0;
  endfunction

  // Cycle count per instruction class (the CPI table).
  function automatic int n_steps(input int c);
    case (c)
      C_RALU, C_SHF, C_IALU, C_SW: return 4;
      C_LW:                        return 5;
      C_BEQ, C_BNE:                return 3;
      default:                     return 2;
    endcase
  endfunction

  // Step k of an instruction's walk: IF, ID, EXE, then MEM for memory ops, else WB.
  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k < 3) return 3'(k);
    if (k == 3 && (c == C_LW || c == C_SW)) return 3'd3;
    return 3'd4;
  endfunction

  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic zz);
    op = o; func = f; z = zz;
`ifdef MCCU_MEM_WAIT_EN
    mem_ready = 1'b1;
`else
    mem_ready = 1'($urandom_range(0, 1));
`endif
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_chk++;
    if ({wpc, wir, wmem, wreg, mem_err} !== 5'b0)
      $display("FAIL reset_we got %b want 00000", {wpc, wir, wmem, wreg, mem_err});
    else n_pass++;
    tick;
    clrn = 1'b1;
  endtask

  task automatic test_reset_mid_exe;
    for (int k = 0; k < 2; k++) begin
      set_in(6'b000000, 6'b100000, 1'b0);
      tick;
    end
    set_in(6'b000000, 6'b100000, 1'b0);
    n_chk++; if (state !== 3'd2) $display("FAIL rmid_pre got %0d want 2", state); else n_pass++;
    clrn = 1'b0;
    #1;
    n_chk++; if (state !== 3'd0) $display("FAIL rmid_state got %0d want 0", state); else n_pass++;
    tick;
    n_chk++;
    if ({wpc, wir, wmem, wreg} !== 4'b0)
      $display("FAIL rmid_we got %b want 0000", {wpc, wir, wmem, wreg});
    else n_pass++;
    n_chk++; if (state !== 3'd0) $display("FAIL rmid_hold got %0d want 0", state); else n_pass++;
    clrn = 1'b1;
  endtask

  task automatic test_add;
    logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    for (int k = 0; k < 4; k++) begin
      set_in(6'b000000, 6'b100000, 1'($urandom_range(0, 1)));
      n_chk++; if (state !== seq[k]) $display("FAIL add_state k=%0d got %0d want %0d", k, state, seq[k]); else n_pass++;
      if (k == 2) begin
        n_chk++;
        if ({aluc, alusrcb, alusrca} !== 7'b0000_00_1)
          $display("FAIL add_exe got %b want 0000001", {aluc, alusrcb, alusrca});
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if ({wreg, regrt, m2reg} !== 3'b100) $display("FAIL add_wb got %b want 100", {wreg, regrt, m2reg}); else n_pass++;
      end
      tick;
    end
    n_chk++; if (state !== 3'd0) $display("FAIL add_end got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_lw_sw;
    for (int k = 0; k < 5; k++) begin
      set_in(6'b100011, 6'($urandom), 1'b0);
      n_chk++; if (state !== 3'(k)) $display("FAIL lw_state k=%0d got %0d want %0d", k, state, k); else n_pass++;
      if (k == 3) begin
        n_chk++; if ({iord, wmem} !== 2'b10) $display("FAIL lw_mem got %b want 10", {iord, wmem}); else n_pass++;
      end
      if (k == 4) begin
        n_chk++;
        if ({wreg, m2reg, regrt} !== 3'b111) $display("FAIL lw_wb got %b want 111", {wreg, m2reg, regrt}); else n_pass++;
      end
      tick;
    end
    for (int k = 0; k < 4; k++) begin
      set_in(6'b101011, 6'($urandom), 1'b0);
      n_chk++; if (state !== 3'(k)) $display("FAIL sw_state k=%0d got %0d want %0d", k, state, k); else n_pass++;
      if (k == 3) begin
        n_chk++;
        if ({iord, wmem, wreg} !== 3'b110) $display("FAIL sw_mem got %b want 110", {iord, wmem, wreg}); else n_pass++;
      end
      tick;
    end
    n_chk++; if (state !== 3'd0) $display("FAIL sw_end got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_branch;
    for (int v = 0; v < 4; v++) begin
      logic [5:0] o;
      logic zz, tk;
      o  = (v < 2) ? 6'b000100 : 6'b000101;
      zz = v[0];
      tk = (v < 2) ? zz : ~zz;
      for (int k = 0; k < 3; k++) begin
        set_in(o, 6'($urandom), zz);
        if (k == 2) begin
          n_chk++;
          if ({wpc, aluc, alusrcb} !== {tk, 4'b0010, 2'b00})
            $display("FAIL br_exe v=%0d got %b want %b", v, {wpc, aluc, alusrcb}, {tk, 4'b0010, 2'b00});
          else n_pass++;
          if (tk) begin
            n_chk++; if (pcsrc !== 2'b01) $display("FAIL br_pcsrc v=%0d got %b want 01", v, pcsrc); else n_pass++;
          end
        end
        tick;
      end
      n_chk++; if (state !== 3'd0) $display("FAIL br_end v=%0d got %0d want 0", v, state); else n_pass++;
    end
  endtask

  task automatic test_jump;
    logic [5:0] o [3] = '{6'b000011, 6'b000000, 6'b111111};
    logic [5:0] f [3] = '{6'b000000, 6'b001000, 6'b000000};
    logic [4:0] e [3] = '{5'b1_11_1_1, 5'b1_10_0_0, 5'b0_00_0_0};
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 2; k++) begin
        set_in(o[v], f[v], 1'b0);
        if (k == 1) begin
          n_chk++;
          if ({wpc, pcsrc, wreg, jal} !== e[v])
            $display("FAIL jmp_id v=%0d got %b want %b", v, {wpc, pcsrc, wreg, jal}, e[v]);
          else n_pass++;
          n_chk++; if ({wir, wmem} !== 2'b00) $display("FAIL jmp_we v=%0d got %b want 00", v, {wir, wmem}); else n_pass++;
        end
        tick;
      end
      n_chk++; if (state !== 3'd0) $display("FAIL jmp_end v=%0d got %0d want 0", v, state); else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      int idx, c, steps;
      logic [5:0] o, f;
      idx = $urandom_range(0, 20);
      if (idx == 20) begin
        c = C_NOP;
        do begin o = 6'($urandom); f = 6'($urandom); end while (is_defined(o, f));
      end else begin
        c = t_cls[idx];
        o = t_op[idx];
        f = (o == 6'd0) ? t_fn[idx] : 6'($urandom);
      end
      steps = n_steps(c);
      for (int k = 0; k < steps; k++) begin
        logic [2:0] st;
        logic zz, tk, e_wpc, e_wir, e_wmem, e_wreg;
        logic [1:0] eb;
        zz = 1'($urandom_range(0, 1));
        set_in(o, f, zz);
        st = exp_state(c, k);
        tk = (c == C_BEQ && zz) || (c == C_BNE && !zz);
        e_wpc  = (st == 3'd0) || (st == 3'd1 && (c == C_J || c == C_JAL || c == C_JR)) || (st == 3'd2 && tk);
        e_wir  = (st == 3'd0);
        e_wmem = (st == 3'd3 && c == C_SW);
        e_wreg = (st == 3'd4) || (st == 3'd1 && c == C_JAL);
        n_chk++; if (state !== st) $display("FAIL rnd_state n=%0d k=%0d got %0d want %0d", n, k, state, st); else n_pass++;
        n_chk++;
        if ({wpc, wir, wmem, wreg, mem_err} !== {e_wpc, e_wir, e_wmem, e_wreg, 1'b0})
          $display("FAIL rnd_we n=%0d op=%b fn=%b k=%0d got %b want %b", n, o, f, k,
                   {wpc, wir, wmem, wreg, mem_err}, {e_wpc, e_wir, e_wmem, e_wreg, 1'b0});
        else n_pass++;
        n_chk++;
        case (st)
          3'd0: if ({iord, alusrca, alusrcb, aluc, pcsrc} !== 10'b0_0_01_0000_00)
                  $display("FAIL rnd_if got %b", {iord, alusrca, alusrcb, aluc, pcsrc}); else n_pass++;
          3'd1: if ({alusrca, alusrcb, aluc} !== 7'b0_11_0000 ||
                    (c == C_J   && {pcsrc, jal} !== 3'b11_0) ||
                    (c == C_JAL && {pcsrc, jal} !== 3'b11_1) ||
                    (c == C_JR  && {pcsrc, jal} !== 3'b10_0))
                  $display("FAIL rnd_id op=%b got %b", o, {alusrca, alusrcb, aluc, pcsrc, jal}); else n_pass++;
          3'd2: begin
            eb = (c == C_RALU || c == C_SHF || c == C_BEQ || c == C_BNE) ? 2'b00 : 2'b10;
            if ({alusrca, alusrcb, aluc, shift, sext} !== {1'b1, eb, t_alu[idx], c == C_SHF, t_sx[idx]} ||
                (tk && pcsrc !== 2'b01))
              $display("FAIL rnd_exe op=%b fn=%b got %b want %b", o, f, {alusrca, alusrcb, aluc, shift, sext},
                       {1'b1, eb, t_alu[idx], c == C_SHF, t_sx[idx]});
            else n_pass++;
          end
          3'd3: if (iord !== 1'b1) $display("FAIL rnd_mem got %b want 1", iord); else n_pass++;
          default: if ({regrt, m2reg} !== {c == C_IALU || c == C_LW, c == C_LW})
                     $display("FAIL rnd_wb op=%b got %b", o, {regrt, m2reg}); else n_pass++;
        endcase
        tick;
      end
    end
    n_chk++; if (state !== 3'd0) $display("FAIL rnd_end got %0d want 0", state); else n_pass++;
  endtask

`ifdef MCCU_MEM_WAIT_EN
  task automatic test_mem_wait;
    for (int k = 0; k < 3; k++) begin set_in(6'b100011, 6'd0, 1'b0); tick; end
    for (int k = 0; k < 4; k++) begin
      op = 6'b100011; mem_ready = (k == 3);
      @(negedge clk);
      n_chk++; if (state !== 3'd3) $display("FAIL wait_mem k=%0d got %0d want 3", k, state); else n_pass++;
      tick;
    end
    n_chk++; if (state !== 3'd4) $display("FAIL wait_wb got %0d want 4", state); else n_pass++;
    set_in(6'b100011, 6'd0, 1'b0);
    tick;
    for (int k = 0; k < 16; k++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({state, wpc, wir, mem_err} !== {3'd0, 2'b00, k == 15})
        $display("FAIL wait_to k=%0d got %b want %b", k, {state, wpc, wir, mem_err}, {3'd0, 2'b00, k == 15});
      else n_pass++;
      tick;
    end
    set_in(6'b111111, 6'd0, 1'b0);
    n_chk++; if ({mem_err, wpc} !== 2'b01) $display("FAIL wait_rec got %b want 01", {mem_err, wpc}); else n_pass++;
    tick;
    set_in(6'b111111, 6'd0, 1'b0);
    tick;
  endtask
`endif

  initial begin
    load_table();
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_jump();
    test_reset_mid_exe();
    test_random();
`ifdef MCCU_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
